// File: rtl/wb_intercon_rr.sv
// Round-robin shared-bus Wishbone interconnect: NM masters onto NS address-decoded slaves, bus locked by CYC.
// Zero-latency ack/data path; grant takes one cycle; unmapped/timeout errors are registered one-cycle pulses.
module wb_intercon_rr #(
    parameter int                    NM         = 2,
    parameter int                    NS         = 8,
    parameter int                    DEC_W      = 3,
    parameter logic [NS*DEC_W-1:0]   SLAVE_BASE = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
    parameter int                    TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NM*32-1:0]    m_adr_i,
    input  logic [NM*32-1:0]    m_dat_i,
    input  logic [NM*4-1:0]     m_sel_i,
    input  logic [NM-1:0]       m_we_i,
    input  logic [NM-1:0]       m_cyc_i,
    input  logic [NM-1:0]       m_stb_i,
    output logic [31:0]         m_dat_o,
    output logic [NM-1:0]       m_ack_o,
    output logic [NM-1:0]       m_err_o,
    output logic [31:0]         s_adr_o,
    output logic [31:0]         s_dat_o,
    output logic [3:0]          s_sel_o,
    output logic                s_we_o,
    output logic [NS-1:0]       s_cyc_o,
    output logic [NS-1:0]       s_stb_o,
    input  logic [NS*32-1:0]    s_dat_i,
    input  logic [NS-1:0]       s_ack_i
);

    localparam int GW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t          r_state, w_state_nxt;
    logic [GW-1:0]   r_gnt, r_last, w_gnt_nxt, w_last_nxt, w_rr_pick;
    logic [15:0]     r_tmo_cnt, w_tmo_nxt;
    logic            r_err, w_err_nxt;

    logic [31:0]     w_adr, w_wdat;
    logic [3:0]      w_sel_b;
    logic            w_we, w_cyc, w_stb;
    logic            w_hit;
    logic [SW-1:0]   w_sel;
    logic            w_slv_ack;
    logic            w_owned, w_ack, w_stall, w_unmapped, w_tmo_hit;

    // Granted master's request signals
    always_comb begin
        w_adr   = '0;
        w_wdat  = '0;
        w_sel_b = '0;
        w_we    = 1'b0;
        w_cyc   = 1'b0;
        w_stb   = 1'b0;
        for (int k = 0; k < NM; k++) begin
            if (r_gnt == GW'(k)) begin
                w_adr   = m_adr_i[k*32 +: 32];
                w_wdat  = m_dat_i[k*32 +: 32];
                w_sel_b = m_sel_i[k*4 +: 4];
                w_we    = m_we_i[k];
                w_cyc   = m_cyc_i[k];
                w_stb   = m_stb_i[k];
            end
        end
    end

    // Descending scan so the lowest matching slave index wins
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (w_adr[31 -: DEC_W] == SLAVE_BASE[i*DEC_W +: DEC_W]) begin
                w_hit = 1'b1;
                w_sel = SW'(i);
            end
        end
    end

    always_comb begin
        w_slv_ack = 1'b0;
        m_dat_o   = '0;
        for (int i = 0; i < NS; i++) begin
            if (w_hit && (w_sel == SW'(i))) begin
                w_slv_ack = s_ack_i[i];
                m_dat_o   = s_dat_i[i*32 +: 32];
            end
        end
    end

    assign w_owned    = (r_state == OWNED);
    assign w_ack      = w_owned & w_hit & w_cyc & w_stb & w_slv_ack;
    assign w_stall    = w_owned & w_hit & w_cyc & w_stb & ~w_slv_ack & ~r_err;
    assign w_unmapped = w_owned & ~w_hit & w_cyc & w_stb & ~r_err;
    assign w_tmo_hit  = w_stall & (r_tmo_cnt == 16'(TIMEOUT - 1));
    assign w_err_nxt  = w_unmapped | w_tmo_hit;
    assign w_tmo_nxt  = (w_stall && !w_tmo_hit) ? r_tmo_cnt + 16'd1 : 16'd0;

    assign s_adr_o = w_adr;
    assign s_dat_o = w_wdat;
    assign s_sel_o = w_sel_b;
    assign s_we_o  = w_we;

    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        for (int i = 0; i < NS; i++) begin
            if (w_owned && w_hit && (w_sel == SW'(i))) begin
                s_cyc_o[i] = w_cyc;
                s_stb_o[i] = w_stb;
            end
        end
        // A slave ack always beats a pending error pulse
        for (int k = 0; k < NM; k++) begin
            if (r_gnt == GW'(k)) begin
                m_ack_o[k] = w_ack;
                m_err_o[k] = w_owned & r_err & ~w_ack;
            end
        end
    end

    // Round-robin search starting just after the last owner
    always_comb begin
        logic found;
        found     = 1'b0;
        w_rr_pick = r_last;
        for (int i = 1; i <= NM; i++) begin
            for (int k = 0; k < NM; k++) begin
                if (!found && (k == (int'(r_last) + i) % NM) && m_cyc_i[k]) begin
                    w_rr_pick = GW'(k);
                    found     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (|m_cyc_i) begin
                    w_state_nxt = OWNED;
                    w_gnt_nxt   = w_rr_pick;
                    w_last_nxt  = w_rr_pick;
                end
            end
            OWNED: begin
                if (!w_cyc) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_last    <= GW'(NM - 1);
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_last    <= w_last_nxt;
            r_tmo_cnt <= w_tmo_nxt;
            r_err     <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_wb_intercon_rr.sv
// Directed bench for wb_intercon_rr: 2 masters, 4 slaves (one base remapped), TIMEOUT=4.
// Terminations are predicted into a scoreboard queue when a transfer is launched and popped when ack/err appears.
module tb_wb_intercon_rr;

    localparam int NM = 2;
    localparam int NS = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NM*32-1:0]   m_adr_i, m_dat_i;
    logic [NM*4-1:0]    m_sel_i;
    logic [NM-1:0]      m_we_i, m_cyc_i, m_stb_i;
    logic [31:0]        m_dat_o;
    logic [NM-1:0]      m_ack_o, m_err_o;
    logic [31:0]        s_adr_o, s_dat_o;
    logic [3:0]         s_sel_o;
    logic               s_we_o;
    logic [NS-1:0]      s_cyc_o, s_stb_o;
    logic [NS*32-1:0]   s_dat_i;
    logic [NS-1:0]      s_ack_i;

    always #5 clk = ~clk;

    // Slave bases: s0=0x0.., s1=0x2.., s2=0x4.., s3=0x8..; 0x6../0x7.. unmapped
    wb_intercon_rr #(
        .NM(NM), .NS(NS), .DEC_W(3),
        .SLAVE_BASE({3'd4, 3'd2, 3'd1, 3'd0}),
        .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    typedef struct {
        int          m;
        logic        is_err;
        logic [31:0] dat;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int k, input logic [31:0] adr, input logic cyc, input logic stb);
        m_adr_i[k*32 +: 32] = adr;
        m_dat_i[k*32 +: 32] = adr ^ 32'h5A5A_0000;
        m_sel_i[k*4 +: 4]   = 4'hF;
        m_we_i[k]           = 1'b0;
        m_cyc_i[k]          = cyc;
        m_stb_i[k]          = stb;
    endtask

    task automatic check_term(input string tag);
        exp_t        e;
        logic [31:0] bit_m;
        chk({tag, "_sb_nonempty"}, 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
            e     = q.pop_front();
            bit_m = 32'd1 << e.m;
            chk({tag, "_ack"}, 32'(m_ack_o), e.is_err ? 32'd0 : bit_m);
            chk({tag, "_err"}, 32'(m_err_o), e.is_err ? bit_m : 32'd0);
            if (!e.is_err) chk({tag, "_dat"}, m_dat_o, e.dat);
        end
    endtask

    task automatic wait_term(input string tag, input int budget, output int cycles);
        cycles = 0;
        while ((m_ack_o | m_err_o) == '0 && cycles < budget) begin
            tick();
            cycles++;
        end
        chk({tag, "_seen"}, 32'((m_ack_o | m_err_o) != '0), 32'd1);
        if ((m_ack_o | m_err_o) != '0) check_term(tag);
        else if (q.size() > 0) q.delete(0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
        m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;
        s_dat_i = '0; s_ack_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
        chk("rst_s_stb", 32'(s_stb_o), 32'd0);
        chk("rst_m_ack", 32'(m_ack_o), 32'd0);
        chk("rst_m_err", 32'(m_err_o), 32'd0);
        rst = 1'b1;

        // Simultaneous requests: master0 first, then round-robin
        set_m(0, 32'h0000_0000, 1'b1, 1'b0);
        set_m(1, 32'h2000_0000, 1'b1, 1'b0);
        tick(); #1;
        chk("arb_first_m0", 32'(s_cyc_o), 32'b0001);
        set_m(0, 32'h0000_0000, 1'b0, 1'b0);
        tick(); #1;
        chk("arb_release", 32'(s_cyc_o), 32'b0000);
        tick(); #1;
        chk("arb_rr_m1", 32'(s_cyc_o), 32'b0010);
        set_m(1, 32'h2000_0000, 1'b0, 1'b0);
        tick();
        set_m(0, 32'h0000_0000, 1'b1, 1'b0);
        set_m(1, 32'h2000_0000, 1'b1, 1'b0);
        tick(); #1;
        chk("arb_back_m0", 32'(s_cyc_o), 32'b0001);
        set_m(0, 32'h0, 1'b0, 1'b0);
        set_m(1, 32'h0, 1'b0, 1'b0);
        tick();

        // Read from slave1 acked two cycles later
        s_dat_i[1*32 +: 32] = 32'hDEAD_BEEF;
        set_m(0, 32'h2000_0004, 1'b1, 1'b1);
        tick(); #1;
        chk("rd_s_stb", 32'(s_stb_o), 32'b0010);
        chk("rd_s_cyc", 32'(s_cyc_o), 32'b0010);
        chk("rd_s_adr", s_adr_o, 32'h2000_0004);
        chk("rd_s_dat", s_dat_o, 32'h2000_0004 ^ 32'h5A5A_0000);
        chk("rd_no_early_ack", 32'(m_ack_o), 32'd0);
        q.push_back('{m: 0, is_err: 1'b0, dat: 32'hDEAD_BEEF});
        tick(); tick();
        s_ack_i[1] = 1'b1;
        #1;
        check_term("rd");
        // Master abandons the cycle while the slave still acks
        tick();
        set_m(0, 32'h2000_0004, 1'b0, 1'b0);
        #1;
        chk("late_ack_hidden", 32'(m_ack_o), 32'd0);
        chk("late_ack_s_cyc", 32'(s_cyc_o), 32'd0);
        tick(); #1;
        chk("late_ack_idle", 32'(m_ack_o), 32'd0);
        s_ack_i = '0;

        // Master1 holds the bus; master0 must wait
        s_dat_i[3*32 +: 32] = 32'h1234_5678;
        set_m(1, 32'h8000_0010, 1'b1, 1'b1);
        tick();
        set_m(0, 32'h4000_0000, 1'b1, 1'b1);
        #1;
        chk("lock_s_stb", 32'(s_stb_o), 32'b1000);
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            chk("lock_m_ack", 32'(m_ack_o), 32'd0);
            chk("lock_m_err", 32'(m_err_o), 32'd0);
        end
        tick();
        s_ack_i[3] = 1'b1;
        q.push_back('{m: 1, is_err: 1'b0, dat: 32'h1234_5678});
        #1;
        check_term("lock_m1");
        set_m(1, 32'h8000_0010, 1'b0, 1'b0);
        s_ack_i = '0;
        tick(); #1;
        chk("lock_idle_stb", 32'(s_stb_o), 32'd0);
        tick(); #1;
        chk("lock_m0_s_stb", 32'(s_stb_o), 32'b0100);
        set_m(0, 32'h0, 1'b0, 1'b0);
        tick();

        // Unmapped address
        s_dat_i = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        set_m(0, 32'h7000_0000, 1'b1, 1'b1);
        tick(); #1;
        chk("unmap_s_stb", 32'(s_stb_o), 32'd0);
        chk("unmap_s_cyc", 32'(s_cyc_o), 32'd0);
        chk("unmap_dat_zero", m_dat_o, 32'd0);
        chk("unmap_no_err_yet", 32'(m_err_o), 32'd0);
        q.push_back('{m: 0, is_err: 1'b1, dat: 32'd0});
        wait_term("unmap", 4, lat);
        chk("unmap_lat", 32'(lat), 32'd1);
        tick(); #1;
        chk("unmap_one_cycle", 32'(m_err_o), 32'd0);
        set_m(0, 32'h0, 1'b0, 1'b0);
        tick();

        // Slave never acks: timeout error after four stalled cycles
        set_m(0, 32'h2000_0000, 1'b1, 1'b1);
        #1;
        q.push_back('{m: 0, is_err: 1'b1, dat: 32'd0});
        wait_term("tmo", 10, lat);
        chk("tmo_lat", 32'(lat), 32'd5);
        tick(); #1;
        chk("tmo_one_cycle", 32'(m_err_o), 32'd0);
        set_m(0, 32'h0, 1'b0, 1'b0);
        tick();

        // Ack on the fourth stalled cycle wins over timeout
        set_m(0, 32'h2000_0000, 1'b1, 1'b1);
        repeat (4) tick();
        s_dat_i[1*32 +: 32] = 32'hCAFE_F00D;
        s_ack_i[1] = 1'b1;
        q.push_back('{m: 0, is_err: 1'b0, dat: 32'hCAFE_F00D});
        #1;
        check_term("tmo_ack_prio");
        tick();
        s_ack_i = '0;
        #1;
        chk("tmo_ack_no_err", 32'(m_err_o), 32'd0);
        set_m(0, 32'h0, 1'b0, 1'b0);
        tick();

        // Asynchronous reset mid-transfer
        set_m(0, 32'h8000_0000, 1'b1, 1'b1);
        tick(); #1;
        chk("arst_pre_stb", 32'(s_stb_o), 32'b1000);
        rst = 1'b0;
        #1;
        chk("arst_s_cyc", 32'(s_cyc_o), 32'd0);
        chk("arst_s_stb", 32'(s_stb_o), 32'd0);
        s_ack_i[3] = 1'b1;
        #1;
        chk("arst_m_ack", 32'(m_ack_o), 32'd0);
        chk("arst_m_err", 32'(m_err_o), 32'd0);
        s_ack_i = '0;
        set_m(1, 32'h2000_0000, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick(); #1;
        chk("arst_m0_first", 32'(s_stb_o), 32'b1000);
        set_m(0, 32'h0, 1'b0, 1'b0);
        set_m(1, 32'h0, 1'b0, 1'b0);
        tick();

        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
